// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, ALU operation codes, opcode/funct values and mux select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_R_EXEC   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_JREG     = 4'd10,
        ST_IMM_EXEC = 4'd11,
        ST_IMM_WB   = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b101;
    localparam logic [2:0] ALU_NOP   = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // R-type functions the ALU can execute; JR is routed separately by the decoder.
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter: counts consecutive stalled cycles of a memory access
// and flags a timeout on the last permitted stall.
module mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [TMO_W-1:0] count;

    assign timeout = active && !mem_ready && (count == TMO_W'(TIMEOUT - 1));

    // Any non-stalled cycle zeroes the count, so every memory state is entered with a clean counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (active && !mem_ready && !timeout) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake, timeout and illegal-opcode traps.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = $clog2(TIMEOUT + 1)
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             sign_xtend,
    output logic [3:0]       state_o,
    output logic             illegal_op,
    output logic             bus_error
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    state_t state, next_state;
    logic   mem_state;
    logic   timeout;
    logic   decode_illegal;

    assign state_o   = state;
    assign mem_state = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    mc_wait_timer #(
        .TIMEOUT(TIMEOUT),
        .TMO_W  (TMO_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (mem_state),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (decode_illegal) illegal_op <= 1'b1;
            if (timeout)        bus_error  <= 1'b1;
        end
    end

    // Opcode is read past DECODE as well; the IR holds it until the next fetch.
    always_comb begin
        next_state     = state;
        decode_illegal = 1'b0;
        pc_write       = 1'b0;
        iord           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        reg_dst        = RD_RT;
        wb_sel         = WB_ALUOUT;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_RT;
        alu_op         = ALU_ADD;
        pc_src         = PC_ALU;
        sign_xtend     = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    if (opcode == OP_RTYPE) begin
                        if (funct == FN_JR)          next_state = ST_JREG;
                        else if (funct_legal(funct)) next_state = ST_R_EXEC;
                        else                         decode_illegal = 1'b1;
                    end else if (opcode[5:3] == 3'b100 || opcode[5:2] == 4'b1010) begin
                        next_state = ST_MEM_ADDR;
                    end else begin
                        case (opcode)
                            OP_BEQ, OP_BNE:                   next_state = ST_BRANCH;
                            OP_J, OP_JAL:                     next_state = ST_JUMP;
                            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = ST_IMM_EXEC;
                            default:                          decode_illegal = 1'b1;
                        endcase
                    end
                    if (decode_illegal) next_state = ST_TRAP;
                end
                ST_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_FUNCT;
                    next_state = ST_R_WB;
                end
                ST_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RD;
                    next_state = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    sign_xtend = 1'b1;
                    next_state = opcode[3] ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) next_state = ST_MEM_WB;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_MDR;
                    next_state = ST_FETCH;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) next_state = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                    next_state = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = RD_RA;
                        wb_sel    = WB_PC;
                    end
                    next_state = ST_FETCH;
                end
                ST_JREG: begin
                    pc_src     = PC_RS;
                    pc_write   = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_IMM_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    sign_xtend = ~opcode[2];
                    case (opcode)
                        OP_SLTI: alu_op = ALU_SLT;
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                    next_state = ST_IMM_WB;
                end
                ST_IMM_WB: begin
                    reg_write  = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_TRAP: begin
                    alu_op = ALU_NOP;
                end
                default: next_state = ST_TRAP;
            endcase
            // A timeout overrides the normal memory-state transition; mem_ready already suppresses it.
            if (timeout) next_state = ST_TRAP;
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != ST_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (next_state == ST_FETCH && state != ST_FETCH) retired_cnt <= retired_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control with TIMEOUT=4;
// perf-counter checks are compiled in when MC_PERF_CNT_EN is defined.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, wb_sel, alu_src_b, pc_src;
    logic       alu_src_a, sign_xtend;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic       illegal_op, bus_error;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    multicycle_control #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .sign_xtend (sign_xtend),
        .state_o    (state_o),
        .illegal_op (illegal_op),
        .bus_error  (bus_error)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn,
                                  input logic z, input logic rdy);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with mem_ready high: strobes must stay low while held in reset.
        rst_n = 1'b0;
        apply_stimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        step();
        check_output("rst_state", 32'(state_o), 32'd0);
        check_output("rst_mem_read", 32'(mem_read), 32'd0);
        check_output("rst_ir_write", 32'(ir_write), 32'd0);
        check_output("rst_pc_write", 32'(pc_write), 32'd0);
        check_output("rst_illegal", 32'(illegal_op), 32'd0);
        check_output("rst_bus_error", 32'(bus_error), 32'd0);

        // ADD: FETCH, DECODE, R_EXEC, R_WB
        rst_n = 1'b1;
        #1;
        check_output("add_fetch_mem_read", 32'(mem_read), 32'd1);
        check_output("add_fetch_ir_write", 32'(ir_write), 32'd1);
        check_output("add_fetch_pc_write", 32'(pc_write), 32'd1);
        check_output("add_fetch_srcb", 32'(alu_src_b), 32'd1);
        check_output("add_fetch_reg_write", 32'(reg_write), 32'd0);
        step();
        check_output("add_decode_state", 32'(state_o), 32'd1);
        check_output("add_decode_srcb", 32'(alu_src_b), 32'd3);
        check_output("add_decode_reg_write", 32'(reg_write), 32'd0);
        step();
        check_output("add_rexec_state", 32'(state_o), 32'd2);
        check_output("add_rexec_srca", 32'(alu_src_a), 32'd1);
        check_output("add_rexec_aluop", 32'(alu_op), 32'd5);
        check_output("add_rexec_reg_write", 32'(reg_write), 32'd0);
        step();
        check_output("add_rwb_state", 32'(state_o), 32'd3);
        check_output("add_rwb_reg_write", 32'(reg_write), 32'd1);
        check_output("add_rwb_reg_dst", 32'(reg_dst), 32'd1);
        step();
        check_output("add_done_state", 32'(state_o), 32'd0);

        // LW with three stalled cycles in MEM_RD; ready arrives exactly at the timeout limit
        apply_stimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        step();
        step();
        check_output("lw_addr_state", 32'(state_o), 32'd4);
        check_output("lw_addr_srcb", 32'(alu_src_b), 32'd2);
        check_output("lw_addr_sext", 32'(sign_xtend), 32'd1);
        apply_stimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            check_output("lw_stall_state", 32'(state_o), 32'd5);
            check_output("lw_stall_mem_read", 32'(mem_read), 32'd1);
            check_output("lw_stall_iord", 32'(iord), 32'd1);
            step();
        end
        apply_stimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        check_output("lw_ready_state", 32'(state_o), 32'd5);
        check_output("lw_ready_mem_read", 32'(mem_read), 32'd1);
        step();
        check_output("lw_wb_state", 32'(state_o), 32'd6);
        check_output("lw_wb_sel", 32'(wb_sel), 32'd1);
        check_output("lw_wb_reg_write", 32'(reg_write), 32'd1);
        check_output("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
        check_output("lw_wb_bus_error", 32'(bus_error), 32'd0);
        step();
        check_output("lw_done_state", 32'(state_o), 32'd0);

        // SW zero-wait
        apply_stimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        step();
        step();
        step();
        check_output("sw_wr_state", 32'(state_o), 32'd7);
        check_output("sw_wr_mem_write", 32'(mem_write), 32'd1);
        check_output("sw_wr_mem_read", 32'(mem_read), 32'd0);
        check_output("sw_wr_iord", 32'(iord), 32'd1);
        step();
        check_output("sw_done_state", 32'(state_o), 32'd0);

        // ANDI zero-extends and uses AND
        apply_stimulus(6'b001100, 6'b000000, 1'b0, 1'b1);
        step();
        step();
        check_output("andi_exec_state", 32'(state_o), 32'd11);
        check_output("andi_exec_sext", 32'(sign_xtend), 32'd0);
        check_output("andi_exec_aluop", 32'(alu_op), 32'd2);
        step();
        check_output("andi_wb_state", 32'(state_o), 32'd12);
        check_output("andi_wb_reg_write", 32'(reg_write), 32'd1);
        step();

        // BNE with zero=1 is not taken
        apply_stimulus(6'b000101, 6'b000000, 1'b1, 1'b1);
        step();
        step();
        check_output("bne_state", 32'(state_o), 32'd8);
        check_output("bne_pc_write", 32'(pc_write), 32'd0);
        check_output("bne_pc_src", 32'(pc_src), 32'd1);
        check_output("bne_aluop", 32'(alu_op), 32'd1);
        step();
        check_output("bne_done_state", 32'(state_o), 32'd0);

        // BEQ with zero=1 is taken
        apply_stimulus(6'b000100, 6'b000000, 1'b1, 1'b1);
        step();
        step();
        check_output("beq_pc_write", 32'(pc_write), 32'd1);
        check_output("beq_pc_src", 32'(pc_src), 32'd1);
        step();

        // JAL writes the link register
        apply_stimulus(6'b000011, 6'b000000, 1'b0, 1'b1);
        step();
        step();
        check_output("jal_state", 32'(state_o), 32'd9);
        check_output("jal_pc_write", 32'(pc_write), 32'd1);
        check_output("jal_reg_write", 32'(reg_write), 32'd1);
        check_output("jal_reg_dst", 32'(reg_dst), 32'd2);
        check_output("jal_wb_sel", 32'(wb_sel), 32'd2);
        check_output("jal_pc_src", 32'(pc_src), 32'd2);
        step();

        // JR
        apply_stimulus(6'b000000, 6'b001000, 1'b0, 1'b1);
        step();
        step();
        check_output("jr_state", 32'(state_o), 32'd10);
        check_output("jr_pc_src", 32'(pc_src), 32'd3);
        check_output("jr_pc_write", 32'(pc_write), 32'd1);
        step();
        check_output("jr_done_state", 32'(state_o), 32'd0);

        // Fetch timeout: four stalled cycles trap
        apply_stimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("tmo_stall_state", 32'(state_o), 32'd0);
        end
        step();
        check_output("tmo_trap_state", 32'(state_o), 32'd13);
        check_output("tmo_bus_error", 32'(bus_error), 32'd1);
        check_output("tmo_mem_read", 32'(mem_read), 32'd0);
        check_output("tmo_illegal", 32'(illegal_op), 32'd0);
        apply_stimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        step();
        check_output("tmo_trap_hold", 32'(state_o), 32'd13);
        check_output("tmo_bus_sticky", 32'(bus_error), 32'd1);

        // One reset edge recovers
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_output("rec_state", 32'(state_o), 32'd0);
        check_output("rec_bus_error", 32'(bus_error), 32'd0);
        check_output("rec_illegal", 32'(illegal_op), 32'd0);

        // Illegal opcode traps
        apply_stimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
        step();
        step();
        check_output("ill_state", 32'(state_o), 32'd13);
        check_output("ill_flag", 32'(illegal_op), 32'd1);
        check_output("ill_bus_error", 32'(bus_error), 32'd0);
        check_output("ill_pc_write", 32'(pc_write), 32'd0);

        // Two zero-wait instructions after reset: ADD (4 cycles) then J (3 cycles)
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        apply_stimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        apply_stimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check_output("perf_state", 32'(state_o), 32'd0);
`ifdef MC_PERF_CNT_EN
        check_output("perf_retired", retired_cnt, 32'd2);
        check_output("perf_cycles", cycle_cnt, 32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS decoder.
- One FSM sequences each instruction through fetch, decode, execute, memory and writeback, over several cycles and one shared memory port.
- Adds a memory wait-state handshake, a timeout trap and illegal-opcode detection.
- Drives PC, IR, register file, ALU and memory muxes of the multi-cycle datapath.

Parameters:
- TIMEOUT, 16, max cycles a memory access may wait for mem_ready before trapping (≥1).
- TMO_W, $clog2(TIMEOUT+1), width of wait counter.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26], sampled in DECODE
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC load enable (unconditional or resolved branch)
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request, held until mem_ready
- mem_write  out  1  memory write request, held until mem_ready
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $ra
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
- alu_op  out  3  ALU operation (package encoding)
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (JR)
- sign_xtend  out  1  1 sign-extend imm, 0 zero-extend
- state_o  out  4  current state, for debug
- illegal_op  out  1  sticky, unknown opcode/funct decoded
- bus_error  out  1  sticky, memory timeout

Behaviour:
- Reset: while rst_n=0 at a clock edge:
  - state←FETCH, wait counter←0, illegal_op←0, bus_error←0.
  - All strobe outputs are forced 0 combinationally while rst_n=0; mux selects are 0.
  - Reset mid-instruction abandons it; no writes issue.
- Outputs are combinational from the state register, plus mem_ready, zero and opcode where stated.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precompute branch target). Next state by opcode:
    - R_TYPE with funct 001000 → JREG; other legal funct → R_EXEC.
    - 100xxx → MEM_ADDR; 1010xx → MEM_ADDR.
    - BEQ/BNE → BRANCH.
    - J/JAL → JUMP.
    - ADDI/SLTI/ANDI/ORI → IMM_EXEC.
    - Else → TRAP with illegal_op set.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNCT → R_WB.
  - R_WB: reg_write=1, reg_dst=01, wb_sel=00 → FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, sign_xtend=1, alu_op=ADD → MEM_RD (load) or MEM_WR (store).
  - MEM_RD: mem_read=1, iord=1. On mem_ready → MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=00, wb_sel=01 → FETCH.
  - MEM_WR: mem_write=1, iord=1. On mem_ready → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01. pc_write = BEQ ? zero : ~zero → FETCH.
  - JUMP: pc_src=10, pc_write=1. For JAL also reg_write=1, reg_dst=10, wb_sel=10 → FETCH.
  - JREG: pc_src=11, pc_write=1 → FETCH.
  - IMM_EXEC: alu_src_a=1, alu_src_b=10, sign_xtend = ~opcode[2] (ANDI/ORI zero-extend), alu_op per opcode → IMM_WB.
  - IMM_WB: reg_write=1, reg_dst=00, wb_sel=00 → FETCH.
  - TRAP: all strobes 0. Absorbing until reset.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and on mem_ready.
  - Increments each stalled cycle in those states.
  - When the counter equals TIMEOUT-1 and mem_ready=0 → TRAP with bus_error set.
  - mem_ready in the same cycle as the limit wins; no trap.
- mem_ready outside memory states is ignored.
- Zero-wait cycle counts: R 4, LW 5, SW 4, imm 4, branch 3, J/JAL/JR 3.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W] and retired_cnt[CNT_W].
  - Both clear on reset and wrap modulo 2^CNT_W.
  - cycle_cnt increments every non-TRAP cycle.
  - retired_cnt increments on each transition into FETCH from a non-FETCH state.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum (4-bit).
  - alu_op encodings: ADD 000, SUB 001, AND 010, OR 011, SLT 100, FUNCT 101, NOP 111.
  - opcode/funct constants; reg_dst, wb_sel and pc_src encodings.
- Sub-module mc_wait_timer: wait counter plus timeout compare, parametrised by TIMEOUT.

Test Plan:
- ADD (opcode 0, funct 100000), mem_ready always 1 → states FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 only in R_WB, reg_dst=01.
- LW with mem_ready delayed 3 cycles in MEM_RD → mem_read and iord held 3 cycles, MEM_WB one cycle later, wb_sel=01.
- BNE with zero=1 → pc_write=0 in BRANCH; BEQ with zero=1 → pc_write=1, pc_src=01.
- JAL → JUMP state: pc_write=1, reg_write=1, reg_dst=10, wb_sel=10.
- mem_ready never asserted in FETCH, TIMEOUT=4 → TRAP after 4 stalled cycles, bus_error=1 sticky. rst_n=0 for one edge → FETCH, flags cleared.
- Opcode 111111 → TRAP, illegal_op=1. With MC_PERF_CNT_EN: retired_cnt=2 after two zero-wait instructions.
